// File: rtl/mb8_arb_pkg.sv
// mb8_arb_pkg: shared arbiter state type and default sizing constants
//   N_DEF         number of requesters
//   DSZ_DEF       data width
//   ASZ_DEF       address width (128K block)
//   BURST_MAX_DEF accesses per grant before a waiting requester preempts
package mb8_arb_pkg;
  localparam int N_DEF = 3;
  localparam int DSZ_DEF = 8;
  localparam int ASZ_DEF = 17;
  localparam int BURST_MAX_DEF = 16;
  typedef enum logic {ARB_IDLE, ARB_OWN} arb_sts;
endpackage

// File: rtl/mb8_arb_rr_pick.sv
// rr_pick: combinational round-robin selector
//   req_i  request vector
//   last_i index of the previous winner; search starts at last_i+1 (mod N)
//   win_o  one-hot winner, all-zero when nothing requests
//   vld_o  any request present
module rr_pick
  import mb8_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [N-1:0]  win_o,
  output logic          vld_o
);
  logic [LW-1:0] idx;
  // Scan from farthest to nearest so the nearest requester after last_i wins.
  always_comb begin
    win_o = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = LW'((int'(last_i) + k) % N);
      win_o = req_i[idx] ? N'(1) << idx : win_o;
    end
  end
  assign vld_o = |req_i;
endmodule

// File: rtl/mb8_arb.sv
// mb8_arb: round-robin arbiter sharing one 8-bit memory block between N requesters
//   clk, rst_n          clock, asynchronous active-low reset
//   req, lock, we       per-requester request, burst lock, write select
//   ai, vi              per-requester address and write data
//   gnt                 registered one-hot grant (zero when idle)
//   vld, vo             per-requester read-valid strobe and broadcast read data
//   mem_we/ai/vo/vi     memory master port (combinational from owner's inputs)
module mb8_arb
  import mb8_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DSZ = DSZ_DEF,
  parameter int ASZ = ASZ_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            lock,
  input  logic [N-1:0]            we,
  input  logic [N-1:0][ASZ-1:0]   ai,
  input  logic [N-1:0][DSZ-1:0]   vi,
  output logic [N-1:0]            gnt,
  output logic [N-1:0]            vld,
  output logic [DSZ-1:0]          vo,
  output logic                    mem_we,
  output logic [ASZ-1:0]          mem_ai,
  output logic [DSZ-1:0]          mem_vo,
  input  logic [DSZ-1:0]          mem_vi
);
  localparam int LW = $clog2(N);
  localparam int BW = $clog2(BURST_MAX) + 1;
  arb_sts state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d, pick_req, pick_oh;
  logic [LW-1:0] own_q, own_d, last_q, last_d, rd_own_q, win_idx;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DSZ-1:0] vo_q;
  logic rd_q, pick_v, acc, rel, cap, chg;
  // While owning, only the other requesters compete for the next grant.
  assign pick_req = state_q == ARB_OWN ? req & ~gnt_q : req;
  rr_pick #(.N(N), .LW(LW)) u_pick (
    .req_i (pick_req),
    .last_i(last_q),
    .win_o (pick_oh),
    .vld_o (pick_v)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) win_idx = pick_oh[i] ? LW'(i) : win_idx;
  end
  assign acc = state_q == ARB_OWN && req[own_q];
  assign rel = !req[own_q] && !lock[own_q];
  // The access that brings the count to BURST_MAX (or any access once saturated).
  assign cap = acc && bcnt_q >= BW'(BURST_MAX - 1);
  assign chg = state_q == ARB_IDLE ? pick_v : rel || (cap && pick_v);
  always_comb begin
    state_d = chg ? (pick_v ? ARB_OWN : ARB_IDLE) : state_q;
    gnt_d = chg ? (pick_v ? pick_oh : '0) : gnt_q;
    own_d = chg ? (pick_v ? win_idx : '0) : own_q;
    last_d = chg && pick_v ? win_idx : last_q;
    bcnt_d = chg ? '0 : (acc && bcnt_q != BW'(BURST_MAX)) ? bcnt_q + 1'b1 : bcnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      own_q <= '0;
      last_q <= LW'(N - 1);
      bcnt_q <= '0;
      rd_q <= 1'b0;
      rd_own_q <= '0;
      vo_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      own_q <= own_d;
      last_q <= last_d;
      bcnt_q <= bcnt_d;
      rd_q <= acc && !we[own_q];
      rd_own_q <= own_q;
      vo_q <= vo;
    end
  end
  assign gnt = gnt_q;
  assign mem_we = acc && we[own_q];
  assign mem_ai = state_q == ARB_OWN ? ai[own_q] : '0;
  assign mem_vo = state_q == ARB_OWN ? vi[own_q] : '0;
  // Read return is steered by the owner captured with the access, not the live grant.
  assign vld = rd_q ? N'(1) << rd_own_q : '0;
  assign vo = rd_q ? mem_vi : vo_q;
endmodule
